// File: rtl/draw_rect_char.sv
// Text-box overlay stage for the VGA pixel pipeline: addresses the text and font ROMs
// and paints glyph pixels over the incoming RGB stream, with timing delayed by 3 pclk.
module draw_rect_char #(
  parameter int          XPOS         = 100,
  parameter int          YPOS         = 100,
  parameter logic [11:0] LETTER_COLOR = 12'hfff
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] X_LO = 12'(XPOS);
  localparam logic [11:0] X_HI = 12'(XPOS + 128);
  localparam logic [11:0] Y_LO = 12'(YPOS);
  localparam logic [11:0] Y_HI = 12'(YPOS + 256);

  typedef struct packed {
    logic [3:0]  yrow;
    logic [2:0]  xbit;
    logic        in_box;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } stage_t;

  logic [10:0] xrel;
  logic [10:0] yrel;
  logic        in_box;
  stage_t      s1_d;
  stage_t      s1;
  stage_t      s2;
  logic        pix;
  logic [11:0] rgb_next;

  // The box test uses the raw counters so wrapped offsets never leak into the overlay
  always_comb begin
    xrel    = hcount_in - X_LO[10:0];
    yrel    = vcount_in - Y_LO[10:0];
    in_box  = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
              ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    char_xy = {yrel[7:4], xrel[6:3]};
    s1_d    = '{yrow: yrel[3:0], xbit: xrel[2:0], in_box: in_box,
                hcount: hcount_in, vcount: vcount_in,
                hsync: hsync_in, vsync: vsync_in,
                hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
  end

  assign char_line = {char_code, s1.yrow};

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= s1_d;
      s2 <= s1;
    end
  end

  // Blanking wins over the glyph overlay
  always_comb begin
    pix      = char_pixels[3'd7 - s2.xbit];
    rgb_next = s2.rgb;
    if (s2.hblnk || s2.vblnk) begin
      rgb_next = 12'h000;
    end else if (s2.in_box && pix) begin
      rgb_next = LETTER_COLOR;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s2.hcount;
      vcount_out <= s2.vcount;
      hsync_out  <= s2.hsync;
      vsync_out  <= s2.vsync;
      hblnk_out  <= s2.hblnk;
      vblnk_out  <= s2.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: behavioural text/font ROMs, streaming scoreboard driven by an
// arithmetic reference model, plus a table of directed overlay vectors.
module tb_draw_rect_char;

  localparam int          XP = 100;
  localparam int          YP = 100;
  localparam logic [11:0] LC = 12'hfff;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [6:0] text_rom [256];
  logic [7:0] font_rom [2048];
  logic       fixed_mode = 1'b0;
  logic [7:0] fixed_pix  = 8'h00;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } out_t;

  out_t exp_q[$];

  typedef struct {
    int          h;
    int          v;
    logic        hb;
    logic        vb;
    logic [7:0]  pix;
    logic [11:0] rgb;
    logic [11:0] exp;
    string       name;
  } vec_t;

  draw_rect_char #(.XPOS(XP), .YPOS(YP), .LETTER_COLOR(LC)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_code(char_code),
    .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    char_code   <= text_rom[char_xy];
    char_pixels <= fixed_mode ? fixed_pix : font_rom[char_line];
  end

  // Reference: which character cell and glyph bit the pixel lands on, by plain arithmetic
  function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] c);
    int         xr, yr;
    logic [6:0] code;
    logic [7:0] p;
    xr = h - XP;
    yr = v - YP;
    if (hb || vb) return 12'h000;
    if (xr >= 0 && xr < 128 && yr >= 0 && yr < 256) begin
      code = text_rom[(yr / 16) * 16 + (xr / 8)];
      p    = font_rom[int'(code) * 16 + (yr % 16)];
      if (p[7 - (xr % 8)]) return LC;
    end
    return c;
  endfunction

  task automatic apply_stimulus(input logic r, input int h, input int v, input logic hs,
                                input logic vs, input logic hb, input logic vb,
                                input logic [11:0] c);
    out_t e, a;
    @(posedge pclk);
    #1;
    if (rst) begin
      foreach (exp_q[i]) exp_q[i] = '0;
    end
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      a = '{hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      total++;
      if (a !== e) begin
        bad++;
        $display("[TB] FAIL stream: got %h expected %h (h=%0d v=%0d)", a, e, e.h, e.v);
      end
    end
    rst       = r;
    hcount_in = h[10:0];
    vcount_in = v[10:0];
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = c;
    if (r) e = '0;
    else e = '{h[10:0], v[10:0], hs, vs, hb, vb, model_rgb(h, v, hb, vb, c)};
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_vec(input vec_t t);
    fixed_pix = t.pix;
    rst       = 1'b0;
    hcount_in = t.h[10:0];
    vcount_in = t.v[10:0];
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    hblnk_in  = t.hb;
    vblnk_in  = t.vb;
    rgb_in    = t.rgb;
    repeat (3) @(posedge pclk);
    #1;
    check_output(t.name, rgb_out, t.exp);
  endtask

  task automatic run_line(input int v);
    for (int h = 0; h < 1056; h++) begin
      apply_stimulus(1'b0, h, v, (h >= 840 && h < 968), (v >= 601 && v < 605),
                     (h >= 800), (v >= 600), 12'($urandom));
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   lines[$];

    foreach (text_rom[i]) text_rom[i] = 7'($urandom);
    foreach (font_rom[i]) font_rom[i] = 8'($urandom);
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;

    // Reset held 3 cycles with random inputs, then random traffic
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, $urandom_range(2047), $urandom_range(2047), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
    for (int i = 0; i < 3000; i++)
      apply_stimulus(i == 1500, $urandom_range(XP + 140, XP - 20),
                     $urandom_range(YP + 270, YP - 20), 1'($urandom), 1'($urandom),
                     ($urandom_range(15) == 0), ($urandom_range(15) == 0), 12'($urandom));

    lines = '{99, 100, 101, 115, 116, 200, 355, 356};
    for (int i = 0; i < 12; i++) lines.push_back($urandom_range(370, 90));
    foreach (lines[i]) run_line(lines[i]);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 0, 0, 0, 0, 1, 1, 12'h000);

    // Address generation and font-address formation
    text_rom[8'h35] = 7'h6d;
    @(posedge pclk);
    #1;
    hcount_in = 11'(XP + 8 * 5);
    vcount_in = 11'(YP + 16 * 3 + 7);
    #1;
    check_output("char_xy", {4'h0, char_xy}, 12'h035);
    @(posedge pclk);
    #1;
    check_output("char_line", {1'b0, char_line}, 12'h6d7);

    fixed_mode = 1'b1;
    vecs.push_back('{XP,       YP,       0, 0, 8'b1000_0001, 12'h0a5, LC,      "bit7"});
    vecs.push_back('{XP + 7,   YP,       0, 0, 8'b1000_0001, 12'h0a5, LC,      "bit0"});
    vecs.push_back('{XP + 3,   YP,       0, 0, 8'b1000_0001, 12'h0a5, 12'h0a5, "bit4_clear"});
    vecs.push_back('{XP - 1,   YP + 50,  0, 0, 8'hff,        12'h123, 12'h123, "left_out"});
    vecs.push_back('{XP + 128, YP + 50,  0, 0, 8'hff,        12'h456, 12'h456, "right_out"});
    vecs.push_back('{XP + 127, YP + 50,  0, 0, 8'hff,        12'h456, LC,      "right_in"});
    vecs.push_back('{XP + 50,  YP + 256, 0, 0, 8'hff,        12'h789, 12'h789, "bottom_out"});
    vecs.push_back('{XP + 50,  YP + 255, 0, 0, 8'hff,        12'h789, LC,      "bottom_in"});
    vecs.push_back('{XP + 50,  YP - 1,   0, 0, 8'hff,        12'habc, 12'habc, "top_out"});
    vecs.push_back('{XP + 50,  YP + 20,  1, 0, 8'hff,        12'h0a5, 12'h000, "hblnk_prio"});
    vecs.push_back('{XP + 50,  YP + 20,  0, 1, 8'hff,        12'h0a5, 12'h000, "vblnk_prio"});
    vecs.push_back('{XP + 50,  YP + 20,  0, 0, 8'h00,        12'h3c3, 12'h3c3, "empty_glyph"});
    foreach (vecs[i]) apply_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
